// File: rtl/alu.sv
// Registered integer ALU: eight ops on a/b, result and status flags one edge after in_valid.
// Latency 1 cycle; no backpressure, accepts a new op every cycle.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_overflow;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_overflow;

  // Extra top bit of w_diff is the unsigned borrow (a < b).
  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign w_diff  = {1'b0, a} - {1'b0, b};
  assign w_shamt = b[SHW-1:0];

  always_comb begin
    w_result   = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (op)
      OP_ADD: begin
        w_result   = w_sum[WIDTH-1:0];
        w_carry    = w_sum[WIDTH];
        w_overflow = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_result   = w_diff[WIDTH-1:0];
        w_carry    = w_diff[WIDTH];
        w_overflow = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_AND:  w_result = a & b;
      OP_OR:   w_result = a | b;
      OP_XOR:  w_result = a ^ b;
      OP_SLL:  w_result = a << w_shamt;
      OP_SRL:  w_result = a >> w_shamt;
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result   <= w_result;
        r_carry    <= w_carry;
        r_overflow <= w_overflow;
      end
    end
  end

  assign out_valid = r_valid;
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign negative  = r_result[MSB];
  assign carry     = r_carry;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: hand-computed results and flags, plus async reset behaviour.
module tb_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .negative  (negative),
    .carry     (carry),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Checks every output against the expected result and flag vector {v,z,n,c,o}.
  task automatic check_all(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_flags);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".flags"}, {27'd0, out_valid, zero, negative, carry, overflow}, {27'd0, exp_flags});
  endtask

  task automatic apply(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top);
    @(negedge clk);
    a        = ta;
    b        = tb;
    op       = top;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    op       = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'd0, 5'b01000);
    @(negedge clk);
    rst = 1'b0;

    //            a             b             op      result        v z n c o
    apply(32'd10,       32'd20,       3'b000); check_all("add",      32'd30,       5'b10000);
    apply(32'd30,       32'd10,       3'b001); check_all("sub_pos",  32'd20,       5'b10000);
    apply(32'd10,       32'd30,       3'b001); check_all("sub_neg",  32'hFFFFFFEC, 5'b10110);
    apply(32'd1,        32'd2,        3'b010); check_all("and",      32'd0,        5'b11000);
    apply(32'd1,        32'd2,        3'b011); check_all("or",       32'd3,        5'b10000);
    apply(32'd1,        32'd2,        3'b100); check_all("xor",      32'd3,        5'b10000);
    apply(32'hFFFFFFFF, 32'd1,        3'b000); check_all("add_wrap", 32'd0,        5'b11010);
    apply(32'h7FFFFFFF, 32'd1,        3'b000); check_all("add_ovf",  32'h80000000, 5'b10101);
    apply(32'h80000000, 32'd1,        3'b001); check_all("sub_ovf",  32'h7FFFFFFF, 5'b10001);
    apply(32'd1,        32'd33,       3'b101); check_all("sll",      32'd2,        5'b10000);
    apply(32'h80000000, 32'd31,       3'b110); check_all("srl",      32'd1,        5'b10000);
    apply(32'hFFFFFFFF, 32'd1,        3'b111); check_all("slt_t",    32'd1,        5'b10000);
    apply(32'd1,        32'hFFFFFFFF, 3'b111); check_all("slt_f",    32'd0,        5'b11000);

    // Reset asserted mid-cycle while back-to-back ops are in flight.
    apply(32'd5, 32'd6, 3'b000);
    check_all("pre_rst", 32'd11, 5'b10000);
    #1;
    a  = 32'd100;
    b  = 32'd1;
    op = 3'b001;
    #1;
    rst = 1'b1;
    #1;
    check_all("async_rst", 32'd0, 5'b01000);
    @(posedge clk);
    #1;
    check_all("rst_held", 32'd0, 5'b01000);

    @(negedge clk);
    rst = 1'b0;
    a   = 32'd2;
    b   = 32'd3;
    op  = 3'b000;
    #1;
    check_all("rst_release", 32'd0, 5'b01000);
    @(posedge clk);
    #1;
    check_all("first_op", 32'd5, 5'b10000);

    @(negedge clk);
    in_valid = 1'b0;
    a        = 32'd7;
    b        = 32'd7;
    op       = 3'b001;
    @(posedge clk);
    #1;
    check_all("idle_hold", 32'd5, 5'b00000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
